// File: rtl/fir_seq.sv
// fir_seq: sequencing controller for the FIR tap/data BRAM datapath.
// Owns the ap_* handshake, data RAM clear, circular x write and MAC address sweep.
module fir_seq #(
  parameter int pADDR_WIDTH = 12,
  parameter int pMAX_TAP    = 32,
  parameter int pTAP_W      = 6
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start,
  input  logic                   done_ack,
  input  logic [pTAP_W-1:0]      tap_num,
  input  logic [31:0]            data_length,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic                   eng_busy,
  input  logic                   ss_tvalid,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [3:0]             data_WE,
  output logic                   data_zero,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic                   tlast_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WAIT_X = 3'd2,
    S_MAC    = 3'd3,
    S_DRAIN  = 3'd4,
    S_OUT    = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam logic [pTAP_W:0] MAX_TAP = (pTAP_W+1)'(pMAX_TAP);
  localparam logic [pTAP_W:0] ONE_T   = (pTAP_W+1)'(1);

  state_e            state_q, state_d;
  logic [pTAP_W-1:0] cnt_q, cnt_d, wptr_q, wptr_d;
  logic [31:0]       x_cnt_q, x_cnt_d;
  logic              last_q, last_d, tlast_err_q, tlast_err_d;
  logic              mac_en_q, mac_clr_q;
  logic [pTAP_W:0]   tap_s, cnt_nxt_s, wptr_nxt_s, rd_idx_s;
  logic [32:0]       x_nxt_s;
  logic              tap_ok_s, cnt_end_s, wptr_wrap_s, x_last_s;

  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [pTAP_W:0] idx);
    return pADDR_WIDTH'({idx, 2'b00});
  endfunction

  // Range checks use >= so a tap_num/data_length change mid-run cannot strand a counter.
  assign tap_s       = {1'b0, tap_num};
  assign cnt_nxt_s   = {1'b0, cnt_q} + ONE_T;
  assign wptr_nxt_s  = {1'b0, wptr_q} + ONE_T;
  assign x_nxt_s     = {1'b0, x_cnt_q} + 33'd1;
  assign tap_ok_s    = (tap_s != '0) && (tap_s <= MAX_TAP);
  assign cnt_end_s   = (cnt_nxt_s >= tap_s);
  assign wptr_wrap_s = (wptr_nxt_s >= tap_s);
  assign x_last_s    = (x_nxt_s >= {1'b0, data_length});

  // Circular read index: newest sample at wptr, k samples back wraps by tap_num.
  always_comb begin
    if (wptr_q >= cnt_q) begin
      rd_idx_s = {1'b0, wptr_q} - {1'b0, cnt_q};
    end else begin
      rd_idx_s = {1'b0, wptr_q} + tap_s - {1'b0, cnt_q};
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wptr_d      = wptr_q;
    x_cnt_d     = x_cnt_q;
    last_d      = last_q;
    tlast_err_d = tlast_err_q;
    case (state_q)
      S_IDLE: begin
        if (ap_start && tap_ok_s) begin
          cnt_d   = '0;
          state_d = (data_length == 32'd0) ? S_DONE : S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (cnt_end_s) begin
          state_d = S_WAIT_X;
          cnt_d   = '0;
          wptr_d  = '0;
          x_cnt_d = 32'd0;
        end else begin
          cnt_d = cnt_nxt_s[pTAP_W-1:0];
        end
      end
      S_WAIT_X: begin
        if (ss_tvalid) begin
          state_d     = S_MAC;
          cnt_d       = '0;
          last_d      = x_last_s;
          tlast_err_d = tlast_err_q | (ss_tlast != x_last_s);
        end else begin
          state_d = S_WAIT_X;
        end
      end
      S_MAC: begin
        if (cnt_end_s) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_nxt_s[pTAP_W-1:0];
        end
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT: begin
        if (sm_tready) begin
          wptr_d  = wptr_wrap_s ? '0 : wptr_nxt_s[pTAP_W-1:0];
          x_cnt_d = x_nxt_s[31:0];
          state_d = last_q ? S_DONE : S_WAIT_X;
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE: begin
        if (done_ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from state and counters.
  always_comb begin
    ap_idle   = 1'b0;
    ap_done   = 1'b0;
    eng_busy  = 1'b0;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tlast  = 1'b0;
    tap_A     = '0;
    data_A    = '0;
    data_WE   = 4'h0;
    data_zero = 1'b0;
    case (state_q)
      S_IDLE: ap_idle = 1'b1;
      S_CLEAR: begin
        eng_busy  = 1'b1;
        data_A    = word_addr({1'b0, cnt_q});
        data_WE   = 4'hF;
        data_zero = 1'b1;
      end
      S_WAIT_X: begin
        eng_busy  = 1'b1;
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          data_A  = word_addr({1'b0, wptr_q});
          data_WE = 4'hF;
        end else begin
          data_WE = 4'h0;
        end
      end
      S_MAC: begin
        eng_busy = 1'b1;
        tap_A    = word_addr({1'b0, cnt_q});
        data_A   = word_addr(rd_idx_s);
      end
      S_DRAIN: eng_busy = 1'b1;
      S_OUT: begin
        eng_busy  = 1'b1;
        sm_tvalid = 1'b1;
        sm_tlast  = last_q;
      end
      S_DONE: ap_done = 1'b1;
      default: ap_idle = 1'b0;
    endcase
  end

  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;
  assign tlast_err = tlast_err_q;

  // State registers; mac_en/mac_clr trail the MAC address by the BRAM read latency.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wptr_q      <= '0;
      x_cnt_q     <= 32'd0;
      last_q      <= 1'b0;
      tlast_err_q <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      x_cnt_q     <= x_cnt_d;
      last_q      <= last_d;
      tlast_err_q <= tlast_err_d;
      mac_en_q    <= (state_q == S_MAC);
      mac_clr_q   <= (state_q == S_MAC) && (cnt_q == '0);
    end
  end

endmodule
